// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_decoder                                             |
// | Description : Receive-side VGA timing decoder. Samples hSync/vSync/RGB on  |
// |               each pixCe strobe. It recovers the active-area x/y, checks    |
// |               line and frame timing, and reports lock. Once locked it      |
// |               forwards each active pixel.                                  |
// | Ports       : clk, reset (async, active-high), pixCe, hSync, vSync,        |
// |               rgbIn[11:0] -> pixValid, x[9:0], y[8:0], rgbOut[11:0],       |
// |               frameStart, locked, lineErr, frameErr, frameCount[15:0]      |
// |               (+ frameCrc[15:0] when VGA_DECODER_CRC_EN is defined)        |
// | Options     : VGA_DECODER_CRC_EN adds a per-frame CRC-16-CCITT of the      |
// |               forwarded pixels.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_sync_decoder #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_FRONT     = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_FRONT     = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixCe,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgbIn,
    output logic        pixValid,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [11:0] rgbOut,
    output logic        frameStart,
    output logic        locked,
    output logic        lineErr,
    output logic        frameErr,
    output logic [15:0] frameCount
`ifdef VGA_DECODER_CRC_EN
    ,
    output logic [15:0] frameCrc
`endif
);

    localparam logic [10:0] c_H_TOTAL = 11'(H_SYNC + H_BACK + WIDTH + H_FRONT);
    localparam logic [10:0] c_V_TOTAL = 11'(V_SYNC + V_BACK + HEIGHT + V_FRONT);
    localparam logic [9:0]  c_H_SYNC  = 10'(H_SYNC);
    localparam logic [9:0]  c_V_SYNC  = 10'(V_SYNC);
    localparam logic [9:0]  c_H_ACT0  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  c_H_ACT1  = 10'(H_SYNC + H_BACK + WIDTH);
    localparam logic [9:0]  c_V_ACT0  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  c_V_ACT1  = 10'(V_SYNC + V_BACK + HEIGHT);
    localparam logic [8:0]  c_Y_OFS   = 9'(V_SYNC + V_BACK);
    localparam logic [7:0]  c_LOCK    = 8'(LOCK_FRAMES);
    localparam logic [9:0]  c_SAT     = 10'h3FF;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_hCnt;
    logic [9:0]  r_vCnt;
    logic        r_hsPrev;      // hSync at previous pixCe
    logic        r_vsAtLs;      // vSync at previous line start
    logic [9:0]  r_hLowCnt;
    logic [9:0]  r_hLowRun;     // length of the most recent completed hSync pulse
    logic [9:0]  r_vLowCnt;
    logic [9:0]  r_vLowRun;     // length (lines) of the most recent completed vSync pulse
    logic [7:0]  r_goodCnt;
    logic        r_chkArm;      // a full line has been seen since entering HUNT

    logic        w_lineStart;
    logic        w_vEdge;
    logic [9:0]  w_hNext;
    logic [9:0]  w_vNext;
    logic        w_lineBad;
    logic        w_frameBad;
    logic        w_errEn;
    logic        w_anyErr;
    logic        w_active;

    assign w_lineStart = ~hSync & r_hsPrev;
    // vSync edge is judged at line-start granularity, so a coincident
    // hSync/vSync fall processes the line start first and then clears vCnt.
    assign w_vEdge     = w_lineStart & ~vSync & r_vsAtLs;

    assign w_hNext = w_lineStart ? 10'd0 :
                     (r_hCnt == c_SAT) ? r_hCnt : r_hCnt + 10'd1;
    assign w_vNext = w_vEdge ? 10'd0 :
                     (w_lineStart && r_vCnt != c_SAT) ? r_vCnt + 10'd1 : r_vCnt;

    // The counters still hold the last index of the line/frame just ended.
    assign w_lineBad  = w_lineStart & r_chkArm &
                        ((({1'b0, r_hCnt} + 11'd1) != c_H_TOTAL) || (r_hLowRun != c_H_SYNC));
    assign w_frameBad = w_vEdge &
                        ((({1'b0, r_vCnt} + 11'd1) != c_V_TOTAL) || (r_vLowRun != c_V_SYNC));
    assign w_errEn    = (r_state != S_HUNT);
    assign w_anyErr   = w_errEn & (w_lineBad | w_frameBad);

    assign w_active = (w_hNext >= c_H_ACT0) && (w_hNext < c_H_ACT1) &&
                      (w_vNext >= c_V_ACT0) && (w_vNext < c_V_ACT1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_HUNT;
            r_hCnt     <= 10'd0;
            r_vCnt     <= 10'd0;
            r_hsPrev   <= 1'b1;
            r_vsAtLs   <= 1'b1;
            r_hLowCnt  <= 10'd0;
            r_hLowRun  <= 10'd0;
            r_vLowCnt  <= 10'd0;
            r_vLowRun  <= 10'd0;
            r_goodCnt  <= 8'd0;
            r_chkArm   <= 1'b0;
            pixValid   <= 1'b0;
            x          <= 10'd0;
            y          <= 9'd0;
            rgbOut     <= 12'd0;
            frameStart <= 1'b0;
            locked     <= 1'b0;
            lineErr    <= 1'b0;
            frameErr   <= 1'b0;
            frameCount <= 16'd0;
        end else begin
            pixValid   <= 1'b0;
            frameStart <= 1'b0;
            lineErr    <= 1'b0;
            frameErr   <= 1'b0;
            if (pixCe) begin
                r_hsPrev <= hSync;
                r_hCnt   <= w_hNext;
                r_vCnt   <= w_vNext;

                if (w_lineStart) begin
                    r_hLowCnt <= 10'd1;
                end else if (!hSync && r_hLowCnt != c_SAT) begin
                    r_hLowCnt <= r_hLowCnt + 10'd1;
                end
                if (hSync && !r_hsPrev) begin
                    r_hLowRun <= r_hLowCnt;
                end

                if (w_lineStart) begin
                    r_vsAtLs <= vSync;
                    r_chkArm <= 1'b1;
                    if (w_vEdge) begin
                        r_vLowCnt <= 10'd1;
                    end else if (!vSync && r_vLowCnt != c_SAT) begin
                        r_vLowCnt <= r_vLowCnt + 10'd1;
                    end
                    if (vSync && !r_vsAtLs) begin
                        r_vLowRun <= r_vLowCnt;
                    end
                end

                lineErr  <= w_errEn & w_lineBad;
                frameErr <= w_errEn & w_frameBad;

                case (r_state)
                    S_HUNT: begin
                        if (w_vEdge) begin
                            r_state   <= S_VERIFY;
                            r_goodCnt <= 8'd0;
                        end
                    end
                    S_VERIFY: begin
                        if (w_anyErr) begin
                            r_state  <= S_HUNT;
                            r_chkArm <= 1'b0;
                        end else if (w_vEdge) begin
                            r_goodCnt <= r_goodCnt + 8'd1;
                            if (r_goodCnt + 8'd1 == c_LOCK) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (w_anyErr) begin
                            r_state  <= S_HUNT;
                            r_chkArm <= 1'b0;
                            locked   <= 1'b0;
                        end else begin
                            if (w_vEdge) begin
                                frameCount <= frameCount + 16'd1;
                            end
                            if (w_active) begin
                                pixValid   <= 1'b1;
                                x          <= w_hNext - c_H_ACT0;
                                y          <= w_vNext[8:0] - c_Y_OFS;
                                rgbOut     <= rgbIn;
                                frameStart <= (w_hNext == c_H_ACT0) && (w_vNext == c_V_ACT0);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_DECODER_CRC_EN
    // Bit-serial CRC-16-CCITT, MSB first.
    function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    logic [15:0] r_crcRun;

    // Frame end is the vSync-edge line start, always far from the last
    // forwarded pixel, so latch and accumulate never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crcRun <= 16'hFFFF;
            frameCrc <= 16'd0;
        end else if (pixCe && w_vEdge) begin
            frameCrc <= r_crcRun;
            r_crcRun <= 16'hFFFF;
        end else if (pixValid) begin
            r_crcRun <= f_crc16(r_crcRun, {rgbOut, 4'h0});
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_sync_decoder                                          |
// | Description : Directed bench for vga_sync_decoder using shrunk timing:     |
// |               14 px/line (3 sync, 2 back, 8 active, 1 front) and 8 lines/  |
// |               frame (2 sync, 1 back, 4 active, 1 front).                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_sync_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixCe = 1'b0;
    logic        hSync = 1'b1;
    logic        vSync = 1'b1;
    logic [11:0] rgbIn = 12'd0;
    logic        pixValid;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] rgbOut;
    logic        frameStart;
    logic        locked;
    logic        lineErr;
    logic        frameErr;
    logic [15:0] frameCount;
`ifdef VGA_DECODER_CRC_EN
    logic [15:0] frameCrc;
`endif

    int total = 0;
    int bad   = 0;
    int cur_i = 0;
    int cur_row = 0;
    int pv_cnt = 0;
    int fs_cnt = 0;
    int le_cnt = 0;
    int fe_cnt = 0;

    vga_sync_decoder #(
        .WIDTH(8), .HEIGHT(4), .H_SYNC(3), .H_BACK(2), .H_FRONT(1),
        .V_SYNC(2), .V_BACK(1), .V_FRONT(1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pixCe(pixCe), .hSync(hSync), .vSync(vSync),
        .rgbIn(rgbIn), .pixValid(pixValid), .x(x), .y(y), .rgbOut(rgbOut),
        .frameStart(frameStart), .locked(locked), .lineErr(lineErr),
        .frameErr(frameErr), .frameCount(frameCount)
`ifdef VGA_DECODER_CRC_EN
        , .frameCrc(frameCrc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pat(input int i, input int row);
        return {4'hF, 4'(i), 4'(row)};
    endfunction

    // One pixel: pixCe high for one clk, then three idle clks.
    task automatic pix(input logic hs, input logic vs, input logic [11:0] rgb);
        @(posedge clk); #1;
        hSync = hs; vSync = vs; rgbIn = rgb; pixCe = 1'b1;
        @(posedge clk); #1;
        pixCe = 1'b0;
        if (pixValid) begin
            pv_cnt++;
            chk("x", 32'(x), 32'(cur_i - 5));
            chk("y", 32'(y), 32'(cur_row - 3));
            chk("rgbOut", 32'(rgbOut), 32'(pat(cur_i, cur_row)));
        end
        if (frameStart) begin
            fs_cnt++;
            chk("fs_pos", {12'd0, pixValid, x, y}, {12'd0, 1'b1, 10'd0, 9'd0});
        end
        if (lineErr)  le_cnt++;
        if (frameErr) fe_cnt++;
        if (lineErr || frameErr) chk("lock_drop", 32'(locked), 32'd0);
        @(posedge clk); #1;
        chk("pulse_1clk", {28'd0, pixValid, frameStart, lineErr, frameErr}, 32'd0);
        @(posedge clk);
    endtask

    task automatic do_line(input int row, input int first, input int len, input int hs_low);
        for (int i = first; i < len; i++) begin
            cur_i = i;
            cur_row = row;
            pix((i < hs_low) ? 1'b0 : 1'b1, (row < 2) ? 1'b0 : 1'b1, pat(i, row));
        end
    endtask

    task automatic clr();
        pv_cnt = 0; fs_cnt = 0; le_cnt = 0; fe_cnt = 0;
    endtask

    task automatic do_frame(input int nlines, input int bad_line, input int bad_len, input int bad_hs);
        clr();
        for (int l = 0; l < nlines; l++) begin
            do_line(l, 0, (l == bad_line) ? bad_len : 14, (l == bad_line) ? bad_hs : 3);
        end
    endtask

    task automatic frame_ok(input string tag, input int pv, input logic lk, input int fc);
        chk({tag, "_pv"}, 32'(pv_cnt), 32'(pv));
        chk({tag, "_fs"}, 32'(fs_cnt), (pv > 0) ? 32'd1 : 32'd0);
        chk({tag, "_lock"}, 32'(locked), 32'(lk));
        chk({tag, "_fc"}, 32'(frameCount), 32'(fc));
    endtask

`ifdef VGA_DECODER_CRC_EN
    function automatic logic [15:0] crc_frame();
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = 16'hFFFF;
        for (int r = 3; r < 7; r++) begin
            for (int i = 5; i < 13; i++) begin
                d = {pat(i, r), 4'h0};
                for (int b = 15; b >= 0; b--) begin
                    fb = c[15] ^ d[b];
                    c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                end
            end
        end
        return c;
    endfunction
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {3'd0, pixValid, x, y, frameStart, locked, lineErr, frameErr},
            32'd0);
        chk("rst_rgb", {4'd0, rgbOut, frameCount}, 32'd0);
        reset = 1'b0;

        // Acquisition: VERIFY at F1 edge, locked at F3 edge
        do_frame(8, -1, 14, 3);  frame_ok("f1", 0, 1'b0, 0);
        chk("f1_err", 32'(le_cnt + fe_cnt), 32'd0);
        do_frame(8, -1, 14, 3);  frame_ok("f2", 0, 1'b0, 0);
        do_frame(8, -1, 14, 3);  frame_ok("f3", 32, 1'b1, 0);
        do_frame(8, -1, 14, 3);  frame_ok("f4", 32, 1'b1, 1);
`ifdef VGA_DECODER_CRC_EN
        chk("crc_f3", 32'(frameCrc), 32'(crc_frame()));
`endif

        // Short line while locked
        do_frame(8, 4, 13, 3);   frame_ok("f5", 16, 1'b0, 2);
        chk("f5_lineErr", 32'(le_cnt), 32'd1);
        do_frame(8, -1, 14, 3);  frame_ok("f6", 0, 1'b0, 2);
        do_frame(8, -1, 14, 3);  frame_ok("f7", 0, 1'b0, 2);
        do_frame(8, -1, 14, 3);  frame_ok("f8", 32, 1'b1, 2);

        // Narrow hSync pulse while locked
        do_frame(8, 4, 14, 2);   frame_ok("f9", 16, 1'b0, 3);
        chk("f9_lineErr", 32'(le_cnt), 32'd1);
        do_frame(8, -1, 14, 3);  frame_ok("f10", 0, 1'b0, 3);
        do_frame(8, -1, 14, 3);  frame_ok("f11", 0, 1'b0, 3);
        do_frame(8, -1, 14, 3);  frame_ok("f12", 32, 1'b1, 3);

        // Frame one line short: frameErr at the next vSync edge
        do_frame(7, -1, 14, 3);  frame_ok("f13", 32, 1'b1, 4);
        do_frame(8, -1, 14, 3);  frame_ok("f14", 0, 1'b0, 4);
        chk("f14_frameErr", 32'(fe_cnt), 32'd1);
        chk("f14_lineErr", 32'(le_cnt), 32'd0);
        do_frame(8, -1, 14, 3);
        do_frame(8, -1, 14, 3);

        // Reset mid-line while locked
        clr();
        for (int l = 0; l < 4; l++) do_line(l, 0, 14, 3);
        do_line(4, 0, 9, 3);
        chk("f17_pre_pv", 32'(pv_cnt), 32'd12);
        #3 reset = 1'b1;
        #1;
        chk("arst_outs", {3'd0, pixValid, x, y, frameStart, locked, lineErr, frameErr},
            32'd0);
        chk("arst_rgb", {4'd0, rgbOut, frameCount}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clr();
        do_line(4, 9, 14, 3);
        for (int l = 5; l < 8; l++) do_line(l, 0, 14, 3);
        frame_ok("f17_post", 0, 1'b0, 0);
        do_frame(8, -1, 14, 3);  frame_ok("f18", 0, 1'b0, 0);
        do_frame(8, -1, 14, 3);  frame_ok("f19", 0, 1'b0, 0);
        do_frame(8, -1, 14, 3);  frame_ok("f20", 32, 1'b1, 0);
        chk("f20_err", 32'(le_cnt + fe_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
